// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
//   Serial receive front end for the CPU's UART peripheral. The asynchronous
//   UART_RX pin is synchronised. Start bits are validated at mid-bit. 8N1
//   frames are deserialised LSB first, and the received byte is held for the
//   memory-mapped UART registers through an RX_EFF / RX_READ handshake.
//
//   Parameters
//     CLKS_PER_BIT  sysclk cycles per bit time (minimum 4)
//
//   Ports
//     sysclk        in   single clock, rising edge
//     reset         in   synchronous, active-high
//     UART_RX       in   asynchronous serial line, idle high
//     RX_READ       in   one-cycle pulse: consumes the held byte, clears flags
//     RX_DATA       out  last valid received byte
//     RX_EFF        out  high while RX_DATA holds an unread byte
//     RX_OVERRUN    out  sticky: a byte overwrote an unread one
//     RX_FRAME_ERR  out  sticky: a stop bit sampled 0
//
//   Build option
//     UART_RX_MAJORITY_EN  when defined, each bit decision is a 2-of-3 vote of
//                          the samples at T-1, T and T+1. It is taken one
//                          cycle later than the single-sample decision at T.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       RX_READ,
    output logic [7:0] RX_DATA,
    output logic       RX_EFF,
    output logic       RX_OVERRUN,
    output logic       RX_FRAME_ERR
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_d;
    logic          eff_d, ovr_d, ferr_d;

    logic rx_meta, rx_s;
    logic bit_val;

    // Two-flop synchroniser. It resets to the idle level, so releasing reset
    // cannot look like a start edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] holds rx_s from one cycle ago and hist_q[1] from two cycles
    // ago. The decision cycle is T+1, so the vote covers T-1, T and T+1.
    // The start decision moves one count later. Data and stop decisions keep
    // the CLKS_PER_BIT-1 end point, because their counter now starts one cycle
    // later. Every bit period therefore stays CLKS_PER_BIT long.
    localparam logic [CW-1:0] START_LAST = CW'(H);

    logic [1:0] hist_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            hist_q <= '1;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    localparam logic [CW-1:0] START_LAST = CW'(H - 1);

    assign bit_val = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = RX_DATA;
        eff_d   = RX_EFF;
        ovr_d   = RX_OVERRUN;
        ferr_d  = RX_FRAME_ERR;

        // A read clears the handshake first. A byte completing on the same
        // edge then overrides eff and ferr, so the new byte wins.
        if (RX_READ) begin
            eff_d  = 1'b0;
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = bit_val;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Return to IDLE at mid-stop-bit so that a back-to-back start
                // edge is not missed.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (bit_val) begin
                        data_d = shift_q;
                        eff_d  = 1'b1;
                        if (RX_EFF && !RX_READ) begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            RX_DATA      <= '0;
            RX_EFF       <= 1'b0;
            RX_OVERRUN   <= 1'b0;
            RX_FRAME_ERR <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            RX_DATA      <= data_d;
            RX_EFF       <= eff_d;
            RX_OVERRUN   <= ovr_d;
            RX_FRAME_ERR <= ferr_d;
        end
    end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front end for the single-cycle CPU's UART peripheral. It synchronises the asynchronous `UART_RX` pin, detects and validates start bits, deserialises 8N1 frames LSB-first and holds each received byte for the memory-mapped UART registers. Those registers consume it through an `RX_EFF`/`RX_READ` handshake. The block runs on the board clock, upstream of the MEM stage's UART register logic.

## Interface
- `CLKS_PER_BIT`, 5208: sysclk cycles per bit time (100 MHz / 19200 baud); minimum 4.
- `sysclk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising `sysclk`.
- `UART_RX`  in  1  asynchronous serial line; idle high.
- `RX_READ`  in  1  one-cycle pulse from the UART registers; consumes the held byte.
- `RX_DATA`  out  8  last valid received byte.
- `RX_EFF`  out  1  high while `RX_DATA` holds an unread byte.
- `RX_OVERRUN`  out  1  sticky; set when a byte overwrote an unread one.
- `RX_FRAME_ERR`  out  1  sticky; set when a stop bit sampled 0.

## Operation
- Input path: 2-flop synchroniser gives `rx_s`. All decisions use `rx_s` only.
- H = floor(CLKS_PER_BIT/2). Bit counter is 0..CLKS_PER_BIT-1. Data-bit index is 0..7.
- FSM states and transitions:
  - IDLE: when `rx_s`==0, go to START and clear the counter.
  - START: when the counter reaches H-1, sample `rx_s`. If 0, go to DATA, clear counter and index. If 1, treat as a glitch and return to IDLE with no flags changed.
  - DATA: when the counter reaches CLKS_PER_BIT-1, sample `rx_s` into shift bit [index] (LSB first) and clear the counter. After index 7 is sampled, go to STOP.
  - STOP: when the counter reaches CLKS_PER_BIT-1, sample `rx_s`. If 1, load `RX_DATA` from the shifter and set `RX_EFF`. If 0, set `RX_FRAME_ERR`; `RX_DATA` and `RX_EFF` are unchanged. Return to IDLE either way.
- Returning to IDLE mid-stop-bit is intentional; back-to-back frames must be received.
- Byte completion while `RX_EFF`==1: `RX_DATA` is overwritten and `RX_OVERRUN` is set.
- `RX_READ`: on the next edge, clears `RX_EFF`, `RX_OVERRUN` and `RX_FRAME_ERR`.
- `RX_READ` coincident with byte completion: the new byte wins.
  - `RX_DATA` = new byte, `RX_EFF` stays 1, `RX_OVERRUN` = 0.
  - A coincident frame error sets `RX_FRAME_ERR` = 1.
- `RX_READ` while `RX_EFF`==0: no effect beyond clearing the sticky flags.
- Reset, including mid-frame: FSM goes to IDLE, counters clear and synchroniser flops are set to 1. All outputs go to 0: `RX_DATA`=8'h00, `RX_EFF`=0, `RX_OVERRUN`=0, `RX_FRAME_ERR`=0. A partial frame is discarded.

## Timing
- Latency: define t0 as the edge on which the first synchroniser flop captures the falling start edge. `RX_EFF` rises at t0 + 2 + H + 9·CLKS_PER_BIT cycles (±1 for pin phase). Add 1 cycle with majority enabled.
- Outputs are registered; no combinational path from `UART_RX` or `RX_READ` to any output.
- Bit-time drift tolerance: ±4 % accumulated over a frame.
- Earliest next start edge accepted: first cycle after re-entering IDLE.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each START/DATA/STOP decision uses a 2-of-3 majority of `rx_s` at counter values T-1, T and T+1, where T is the nominal sample point.
  - The decision is taken at T+1, and the state advance is delayed by 1 cycle only for that bit.
  - The counter then restarts so that bit periods stay CLKS_PER_BIT.
- Undefined: single sample at T exactly as in Operation; no extra latency.

## Test plan
- CLKS_PER_BIT=16; send 0x41 (start, 1,0,0,0,0,0,1,0, stop) -> `RX_DATA`=0x41, `RX_EFF`=1 at the specified latency; `RX_READ` pulse -> `RX_EFF`=0 next cycle.
- Low glitch of 4 cycles on idle line -> FSM back to IDLE, `RX_EFF`=0, no flag set. Then send 0x55 -> `RX_DATA`=0x55.
- Send 0xA5 with stop bit 0 -> `RX_FRAME_ERR`=1, `RX_EFF`=0, `RX_DATA` unchanged (0x00 after reset).
- Send 0x12 then 0x34 back-to-back without `RX_READ` -> `RX_DATA`=0x34, `RX_EFF`=1, `RX_OVERRUN`=1. Repeat with `RX_READ` on the exact completion cycle of 0x34 -> `RX_EFF`=1, `RX_OVERRUN`=0.
- Assert `reset` during data bit 3 of a frame -> all outputs 0 next edge. Release and send 0xC3 -> `RX_DATA`=0xC3.
- With `UART_RX_MAJORITY_EN`: inject a 1-cycle inverted glitch at the mid-point of bit 2 of 0x0F -> `RX_DATA`=0x0F. Without the macro, same stimulus -> `RX_DATA`=0x0B.
